// File: rtl/mul_booth_arbiter.sv
// Round-robin front end that shares one Booth multiplier among N_REQ clients.
// It captures operands, sequences the start pulse, waits for the end flag
// under a watchdog, and returns the result with a one-cycle done pulse.
module mul_booth_arbiter #(
  parameter int BIT_LEN = 4,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BIT_LEN-1:0]   in1_bus,
  input  logic [N_REQ*BIT_LEN-1:0]   in2_bus,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [2*BIT_LEN-1:0]       result,
  output logic                       err,
  output logic [BIT_LEN-1:0]         mul_in1,
  output logic [BIT_LEN-1:0]         mul_in2,
  output logic                       mul_start,
  input  logic [2*BIT_LEN-1:0]       mul_out,
  input  logic                       mul_out_r
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WW-1:0]          wdog_q, wdog_d;
  logic [2*BIT_LEN-1:0]   result_q, result_d;
  logic                   err_q, err_d;
  logic [BIT_LEN-1:0]     mul_in1_q, mul_in1_d;
  logic [BIT_LEN-1:0]     mul_in2_q, mul_in2_d;

  logic                   pick_vld;
  logic [IW-1:0]          pick_idx;

  // First set request at or above ptr, wrapping modulo N_REQ; returns {valid, index}.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [IW-1:0]    ptr);
    logic          found;
    logic [IW-1:0] sel;
    int unsigned   j;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
    return {found, sel};
  endfunction

  // Round-robin choice among current requests.
  always_comb begin
    {pick_vld, pick_idx} = rr_pick(req, rr_ptr_q);
  end

  // Next-state, datapath updates and decoded outputs.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    wdog_d    = wdog_q;
    result_d  = result_q;
    err_d     = err_q;
    mul_in1_d = mul_in1_q;
    mul_in2_d = mul_in2_q;
    gnt       = '0;
    done      = '0;
    result    = '0;
    err       = 1'b0;
    mul_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          idx_d     = pick_idx;
          mul_in1_d = in1_bus[pick_idx*BIT_LEN +: BIT_LEN];
          mul_in2_d = in2_bus[pick_idx*BIT_LEN +: BIT_LEN];
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        gnt[idx_q] = 1'b1;
        mul_start  = 1'b1;
        wdog_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        gnt[idx_q] = 1'b1;
        // End flag takes priority over a watchdog expiry in the same cycle.
        if (mul_out_r) begin
          result_d = mul_out;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DONE: begin
        gnt[idx_q]  = 1'b1;
        done[idx_q] = 1'b1;
        result      = result_q;
        err         = err_q;
        rr_ptr_d    = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      wdog_q    <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      mul_in1_q <= '0;
      mul_in2_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
      wdog_q    <= wdog_d;
      result_q  <= result_d;
      err_q     <= err_d;
      mul_in1_q <= mul_in1_d;
      mul_in2_q <= mul_in2_d;
    end
  end

  assign mul_in1 = mul_in1_q;
  assign mul_in2 = mul_in2_q;

endmodule
